// File: rtl/vector_fetch_pkg.sv
// Shared definitions for the vector fetch unit.
//   state_t     : sequencer states
//   vec_src_t   : encoding of the vector source being serviced
//   VEC_*       : vector base addresses (low byte; high byte is base+1)
//   vec_base()  : maps a source to its vector base address
package vector_fetch_pkg;

  typedef enum logic [2:0] {
    START    = 3'd0,
    IDLE     = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_BRK   = 2'd2,
    SRC_IRQ   = 2'd3
  } vec_src_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  // BRK and IRQ share a vector.
  function automatic logic [15:0] vec_base(input vec_src_t src);
    logic [15:0] base;
    case (src)
      SRC_NMI:   base = VEC_NMI;
      SRC_RESET: base = VEC_RESET;
      default:   base = VEC_IRQ;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/vector_fetch_if.sv
// Bundle between the CPU core and the vector fetch unit.
//   Requests : nmi, irq, irq_mask, brk_req, instr_boundary
//   Memory   : mem_ready (in), mem_addr, mem_rd (out)
//   PC/flags : pcl_load, pch_load, busy, set_i, vec_src (out)
// slave  = the vector fetch unit, master = the core side driving requests.
interface vector_fetch_if;
  import vector_fetch_pkg::*;

  logic        nmi;
  logic        irq;
  logic        irq_mask;
  logic        brk_req;
  logic        instr_boundary;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        pcl_load;
  logic        pch_load;
  logic        busy;
  logic        set_i;
  vec_src_t    vec_src;

  modport slave (
    input  nmi, irq, irq_mask, brk_req, instr_boundary, mem_ready,
    output mem_addr, mem_rd, pcl_load, pch_load, busy, set_i, vec_src
  );

  modport master (
    output nmi, irq, irq_mask, brk_req, instr_boundary, mem_ready,
    input  mem_addr, mem_rd, pcl_load, pch_load, busy, set_i, vec_src
  );

endinterface

// File: rtl/vector_fetch_nmi_latch.sv
// NMI edge detector with a sticky pending flag.
//   clk, reset : clock and synchronous active-high reset
//   nmi        : raw NMI line
//   clr        : clear request (end of the NMI sequence)
//   edge_det   : combinational 0->1 detect of nmi this cycle
//   pend       : pending flag; an edge in the same cycle as clr wins
module nmi_latch (
  input  logic clk,
  input  logic reset,
  input  logic nmi,
  input  logic clr,
  output logic edge_det,
  output logic pend
);

  logic nmi_q;

  assign edge_det = nmi & ~nmi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (edge_det)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_fetch.sv
// Interrupt/reset vector fetch sequencer. Reads the two vector bytes and
// steers them into the PC, then requests the I flag be set.
//   clk, reset : clock and synchronous active-high reset
//   bus        : vector_fetch_if.slave (requests in, memory and PC controls out)
//
// state    | meaning
// ---------+-----------------------------------------------
// START    | one dead cycle after reset, then RESET fetch
// IDLE     | waiting for an instruction boundary + request
// FETCH_LO | reading vector low byte at base
// FETCH_HI | reading vector high byte at base+1
// DONE     | set_i pulse, clear serviced pending flag
module vector_fetch
  import vector_fetch_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  vector_fetch_if.slave  bus
);

  state_t      state;
  vec_src_t    vec_src_q;
  logic        brk_pend;
  logic        nmi_edge;
  logic        nmi_pend;
  logic        nmi_clr;
  logic        nmi_now;
  logic        brk_now;
  logic        irq_now;
  logic        in_fetch;
  logic [15:0] base;

  assign nmi_clr = (state == DONE) && (vec_src_q == SRC_NMI);

  nmi_latch u_nmi_latch (
    .clk      (clk),
    .reset    (reset),
    .nmi      (bus.nmi),
    .clr      (nmi_clr),
    .edge_det (nmi_edge),
    .pend     (nmi_pend)
  );

  // Requests arriving in the decision cycle itself count as pending.
  assign nmi_now = nmi_pend | nmi_edge;
  assign brk_now = brk_pend | bus.brk_req;
  assign irq_now = bus.irq & ~bus.irq_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= START;
      vec_src_q <= SRC_RESET;
      brk_pend  <= 1'b0;
    end else begin
      if (bus.brk_req)
        brk_pend <= 1'b1;
      else if ((state == DONE) && (vec_src_q == SRC_BRK))
        brk_pend <= 1'b0;

      case (state)
        START:    state <= FETCH_LO;
        IDLE: begin
          if (bus.instr_boundary && (nmi_now || brk_now || irq_now)) begin
            if (nmi_now)
              vec_src_q <= SRC_NMI;
            else if (brk_now)
              vec_src_q <= SRC_BRK;
            else
              vec_src_q <= SRC_IRQ;
            state <= FETCH_LO;
          end
        end
        FETCH_LO: if (bus.mem_ready) state <= FETCH_HI;
        FETCH_HI: if (bus.mem_ready) state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= START;
      endcase
    end
  end

  // Outputs decode from the state register. Reset masks them immediately so
  // an in-flight fetch produces no further loads in the reset cycle.
  assign base     = vec_base(vec_src_q);
  assign in_fetch = !reset && ((state == FETCH_LO) || (state == FETCH_HI));

  assign bus.mem_rd   = in_fetch;
  assign bus.mem_addr = !in_fetch ? VEC_RESET :
                        (state == FETCH_HI) ? base + 16'd1 : base;
  assign bus.pcl_load = !reset && (state == FETCH_LO) && bus.mem_ready;
  assign bus.pch_load = !reset && (state == FETCH_HI) && bus.mem_ready;
  assign bus.busy     = reset || (state != IDLE);
  assign bus.set_i    = !reset && (state == DONE);
  assign bus.vec_src  = vec_src_q;

endmodule

// File: tb/tb_vector_fetch.sv
module tb_vector_fetch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nmi = 1'b0, irq = 1'b0, irq_mask = 1'b1, brk_req = 1'b0;
  logic instr_boundary = 1'b0, mem_ready = 1'b1;

  int total = 0;
  int bad = 0;

  vector_fetch_if vif ();

  assign vif.nmi            = nmi;
  assign vif.irq            = irq;
  assign vif.irq_mask       = irq_mask;
  assign vif.brk_req        = brk_req;
  assign vif.instr_boundary = instr_boundary;
  assign vif.mem_ready      = mem_ready;

  vector_fetch dut (.clk(clk), .reset(reset), .bus(vif));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position within a vector sequence (-1 idle,
  // 0 dead cycle, 1 low byte, 2 high byte, 3 finish) plus pending requests.
  int m_pos = 0;
  int m_src = 0;
  bit m_pnmi = 0, m_pbrk = 0, m_nmi_prev = 0, m_valid = 0;

  function automatic int base_of(input int src);
    if (src == 1) return 32'hFFFA;
    if (src == 0) return 32'hFFFC;
    return 32'hFFFE;
  endfunction

  always @(posedge clk) begin : model
    bit nedge, nmi_now, brk_now, irq_now, np_nmi, np_brk;
    int npos, nsrc;
    if (reset) begin
      m_pos <= 0; m_src <= 0; m_pnmi <= 0; m_pbrk <= 0; m_nmi_prev <= 0; m_valid <= 1;
    end else begin
      nedge   = nmi && !m_nmi_prev;
      nmi_now = m_pnmi || nedge;
      brk_now = m_pbrk || brk_req;
      irq_now = irq && !irq_mask;
      np_nmi = m_pnmi;
      np_brk = m_pbrk;
      if (m_pos == 3 && m_src == 1) np_nmi = 0;
      if (m_pos == 3 && m_src == 2) np_brk = 0;
      if (nedge) np_nmi = 1;
      if (brk_req) np_brk = 1;
      npos = m_pos;
      nsrc = m_src;
      case (m_pos)
        -1: if (instr_boundary && (nmi_now || brk_now || irq_now)) begin
              npos = 1;
              nsrc = nmi_now ? 1 : (brk_now ? 2 : 3);
            end
        0: npos = 1;
        1: if (mem_ready) npos = 2;
        2: if (mem_ready) npos = 3;
        default: npos = -1;
      endcase
      m_pos <= npos; m_src <= nsrc; m_pnmi <= np_nmi; m_pbrk <= np_brk; m_nmi_prev <= nmi;
    end
  end

  always @(negedge clk) begin : compare
    bit rd;
    if (m_valid) begin
      rd = !reset && (m_pos == 1 || m_pos == 2);
      chk("m_busy", vif.busy, reset || m_pos != -1);
      chk("m_mem_rd", vif.mem_rd, rd);
      chk("m_mem_addr", vif.mem_addr, rd ? base_of(m_src) + m_pos - 1 : 32'hFFFC);
      chk("m_pcl_load", vif.pcl_load, !reset && m_pos == 1 && mem_ready);
      chk("m_pch_load", vif.pch_load, !reset && m_pos == 2 && mem_ready);
      chk("m_set_i", vif.set_i, !reset && m_pos == 3);
      chk("m_vec_src", vif.vec_src, m_src);
    end
  end

  bit cnt_en = 0;
  int pcl_cnt = 0, pch_cnt = 0;
  always @(negedge clk) if (cnt_en) begin
    pcl_cnt <= pcl_cnt + int'(vif.pcl_load);
    pch_cnt <= pch_cnt + int'(vif.pch_load);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && vif.busy; i++) cyc();
    chk("idle_reached", vif.busy, 0);
  endtask

  initial begin
    // Reset: 3 cycles, release with mem_ready=1.
    repeat (3) cyc();
    reset = 1'b0;
    #1 chk("rst_start_busy", vif.busy, 1); chk("rst_start_rd", vif.mem_rd, 0);
    cyc(); chk("rst_lo_addr", vif.mem_addr, 16'hFFFC); chk("rst_lo_pcl", vif.pcl_load, 1);
    chk("rst_lo_src", vif.vec_src, 0);
    cyc(); chk("rst_hi_addr", vif.mem_addr, 16'hFFFD); chk("rst_hi_pch", vif.pch_load, 1);
    cyc(); chk("rst_set_i", vif.set_i, 1);
    cyc(); chk("rst_busy_drop", vif.busy, 0);

    // Simultaneous NMI edge, BRK, unmasked IRQ.
    nmi = 1; brk_req = 1; irq = 1; irq_mask = 0; instr_boundary = 1;
    cyc(); brk_req = 0; instr_boundary = 0;
    #1 chk("sim_nmi_src", vif.vec_src, 1); chk("sim_nmi_lo", vif.mem_addr, 16'hFFFA);
    cyc(); chk("sim_nmi_hi", vif.mem_addr, 16'hFFFB);
    cyc(); cyc(); chk("sim_idle1", vif.busy, 0);
    instr_boundary = 1;
    cyc(); instr_boundary = 0;
    #1 chk("sim_brk_src", vif.vec_src, 2); chk("sim_brk_lo", vif.mem_addr, 16'hFFFE);
    cyc(); cyc(); cyc();
    instr_boundary = 1;
    cyc(); instr_boundary = 0;
    #1 chk("sim_irq_src", vif.vec_src, 3); chk("sim_irq_lo", vif.mem_addr, 16'hFFFE);
    irq = 0; nmi = 0;
    wait_idle();

    // Masked IRQ over 10 boundaries, then unmask.
    irq = 1; irq_mask = 1; instr_boundary = 1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("mask_rd", vif.mem_rd, 0); chk("mask_busy", vif.busy, 0);
      cyc();
    end
    irq_mask = 0;
    cyc(); instr_boundary = 0; irq = 0;
    #1 chk("unmask_src", vif.vec_src, 3); chk("unmask_rd", vif.mem_rd, 1);
    wait_idle();

    // Wait states in both fetch phases (BRK).
    mem_ready = 0; brk_req = 1; instr_boundary = 1; cnt_en = 1;
    cyc(); brk_req = 0; instr_boundary = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ws_lo_addr", vif.mem_addr, 16'hFFFE); chk("ws_lo_pcl", vif.pcl_load, 0);
      chk("ws_lo_rd", vif.mem_rd, 1);
      cyc();
    end
    mem_ready = 1;
    #1 chk("ws_lo_load", vif.pcl_load, 1);
    cyc(); mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ws_hi_addr", vif.mem_addr, 16'hFFFF); chk("ws_hi_pch", vif.pch_load, 0);
      cyc();
    end
    mem_ready = 1;
    #1 chk("ws_hi_load", vif.pch_load, 1);
    cyc();
    #1 chk("ws_set_i", vif.set_i, 1);
    cnt_en = 0;
    chk("ws_pcl_count", pcl_cnt, 1); chk("ws_pch_count", pch_cnt, 1);
    wait_idle();

    // NMI edge during FETCH_HI of a BRK sequence.
    brk_req = 1; instr_boundary = 1;
    cyc(); brk_req = 0; instr_boundary = 0;
    cyc(); nmi = 1;
    #1 chk("nsv_brk_hi", vif.mem_addr, 16'hFFFF);
    cyc(); cyc(); chk("nsv_brk_done", vif.busy, 0); chk("nsv_brk_src", vif.vec_src, 2);
    instr_boundary = 1;
    cyc(); instr_boundary = 0;
    #1 chk("nsv_nmi_src", vif.vec_src, 1); chk("nsv_nmi_lo", vif.mem_addr, 16'hFFFA);
    wait_idle();
    instr_boundary = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("nsv_no_second", vif.mem_rd, 0);
      cyc();
    end
    instr_boundary = 0; nmi = 0;
    cyc();

    // Reset in FETCH_HI of an NMI sequence.
    nmi = 1; instr_boundary = 1;
    cyc(); nmi = 0; instr_boundary = 0;
    #1 chk("rmf_nmi_lo", vif.mem_addr, 16'hFFFA);
    cyc(); reset = 1;
    #1 chk("rmf_no_pch", vif.pch_load, 0); chk("rmf_rd", vif.mem_rd, 0);
    chk("rmf_addr", vif.mem_addr, 16'hFFFC); chk("rmf_busy", vif.busy, 1);
    cyc(); reset = 0;
    #1 chk("rmf_start", vif.mem_rd, 0);
    cyc(); chk("rmf_lo", vif.mem_addr, 16'hFFFC); chk("rmf_src", vif.vec_src, 0);
    cyc(); chk("rmf_hi", vif.mem_addr, 16'hFFFD); chk("rmf_pch", vif.pch_load, 1);
    cyc(); cyc();
    instr_boundary = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rmf_nmi_dropped", vif.mem_rd, 0);
      cyc();
    end
    instr_boundary = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vector_fetch.md
VECTOR_FETCH -- requirements
Module: vector_fetch

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- nmi  in  1  NMI line; a 0->1 transition is a request.
- irq  in  1  IRQ line, level-sensitive.
- irq_mask  in  1  CPU I flag; 1 blocks irq.
- brk_req  in  1  one-cycle pulse from the decoder requesting BRK.
- instr_boundary  in  1  high in the cycle a new vector sequence may begin.
- mem_ready  in  1  high when the read data bus holds valid data for mem_addr.
- mem_addr  out  16  vector read address.
- mem_rd  out  1  vector read request.
- pcl_load  out  1  drives the PC low-byte load from the data bus.
- pch_load  out  1  drives the PC high-byte load from the data bus.
- busy  out  1  high while a sequence is active; stalls the decoder and PC increment.
- set_i  out  1  one-cycle pulse requesting the I flag be set.
- vec_src  out  2  source being serviced: 0 RESET, 1 NMI, 2 BRK, 3 IRQ.

Function
REQ-002 The module SHALL implement the states START, IDLE, FETCH_LO, FETCH_HI and DONE.
REQ-003 Vector base addresses SHALL be: RESET 16'hFFFC, NMI 16'hFFFA, BRK and IRQ 16'hFFFE.
REQ-004 START SHALL drive busy=1 and mem_rd=0, and SHALL go to FETCH_LO unconditionally after one cycle.
REQ-005 FETCH_LO SHALL drive mem_addr=base and mem_rd=1; pcl_load SHALL equal mem_ready combinationally; on mem_ready the state SHALL go to FETCH_HI.
REQ-006 FETCH_HI SHALL drive mem_addr=base+1 and mem_rd=1; pch_load SHALL equal mem_ready; on mem_ready the state SHALL go to DONE.
REQ-007 Any number of wait cycles (mem_ready=0) SHALL hold the state, mem_addr and mem_rd, with both load outputs at 0.
REQ-008 DONE SHALL pulse set_i=1 for one cycle, clear the pending flag of vec_src, and go to IDLE.
REQ-009 IDLE SHALL drive busy=0 and mem_rd=0.
REQ-010 In IDLE, when instr_boundary=1 and a request is pending, the module SHALL latch the highest-priority source into vec_src and go to FETCH_LO.
REQ-011 Priority SHALL be NMI > BRK > IRQ.
REQ-012 IRQ SHALL count as pending only when irq=1 and irq_mask=0 in the decision cycle; IRQ SHALL NOT be latched.
REQ-013 A registered copy of nmi SHALL detect rising edges, and each edge SHALL set nmi_pend.
REQ-014 brk_req=1 SHALL set brk_pend.
REQ-015 When a set and a clear of the same pending flag occur in the same cycle, the set SHALL win.
REQ-016 nmi_pend SHALL remain set until its own DONE; an NMI edge that arrives during a BRK or IRQ sequence SHALL be serviced at the next boundary.
REQ-017 vec_src SHALL hold its value from the latch cycle through DONE.
REQ-018 busy SHALL be 1 in START, FETCH_LO, FETCH_HI and DONE.
REQ-019 pcl_load and pch_load SHALL never be high in the same cycle.
REQ-020 In every cycle where mem_rd=0, mem_addr SHALL be 16'hFFFC.
REQ-021 vec_src=RESET SHALL only ever be the value applied at reset.

Reset
REQ-022 While reset=1, the module SHALL set state=START, vec_src=0 (RESET), and nmi_pend, brk_pend and the nmi history register to 0.
REQ-023 While reset=1, the outputs SHALL be: busy=1, mem_rd=0, pcl_load=0, pch_load=0, set_i=0, mem_addr=16'hFFFC.
REQ-024 Reset asserted in any state, including mid-fetch, SHALL abort the sequence with no further loads, and SHALL restart with a RESET vector fetch.

Structure
REQ-025 A shared package SHALL hold the state enum, the vec_src encoding, and the vector base constants VEC_NMI, VEC_RESET and VEC_IRQ.
REQ-026 The NMI edge detector and pending flag SHALL be one sub-module, nmi_latch; everything else SHALL be flat.

Verification
REQ-027 Reset test: hold reset 3 cycles, then release with mem_ready=1 -> START for 1 cycle; mem_addr FFFC with pcl_load; FFFD with pch_load; then set_i; busy drops 4 cycles after release.
REQ-028 Simultaneous requests: nmi rising edge, brk_req and irq=1 with irq_mask=0 all in one IDLE boundary cycle -> vec_src=1 and addr FFFA/FFFB; at the next boundary vec_src=2 (FFFE), then IRQ while irq is still high.
REQ-029 Masked IRQ: irq=1, irq_mask=1 over 10 boundaries -> mem_rd stays 0 and busy stays 0; clearing the mask -> IRQ fetch starts at the next boundary.
REQ-030 Wait states: mem_ready low for 3 cycles in each of FETCH_LO and FETCH_HI -> address held, no loads during waits, exactly one pcl_load and one pch_load.
REQ-031 NMI during service: nmi edge arrives while in FETCH_HI of a BRK sequence -> BRK completes, then an NMI sequence starts at the next boundary; nmi held high afterwards -> no second NMI.
REQ-032 Reset mid-fetch: assert reset in FETCH_HI of an NMI sequence -> pch_load stays 0, then a full FFFC/FFFD sequence follows and the NMI is not serviced.
